reg_file_wb: RTL and testbench
==============================

Name: reg_file_wb

Overview:
- Writeback stage and register bank. Sits directly downstream of the ALU output latch.
- Consumes the latched destination register, result and write-enable, and commits the result into a 32x32 register file.
- Provides two bypassed read ports to the decode stage.
- Tracks in-flight writes per register with a small scoreboard so decode can stall on read-after-write hazards.

Parameters:
- NREGS, 32, number of architectural registers; fixed 5-bit index.
- XLEN, 32, data width.
- PEND_W, 2, width of each per-register pending-write counter; max value 2^PEND_W-1.

Ports:
- stg_clk  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; state clears immediately when low.
- stg_ena  in  1  stage advance enable; when 0, no writeback commits and no scoreboard updates.
- wb_rd  in  5  destination register from ALU latch.
- wb_c  in  32  result from ALU latch.
- wb_save  in  1  write-enable from ALU latch.
- rs1  in  5  decode read address A.
- rs2  in  5  decode read address B.
- rd1  out  32  read data A (combinational, bypassed).
- rd2  out  32  read data B (combinational, bypassed).
- iss_valid  in  1  decode issues an instruction this cycle.
- iss_rd  in  5  destination of the issuing instruction.
- iss_wr  in  1  issuing instruction will write iss_rd.
- hazard  out  1  rs1 or rs2 has an outstanding write not resolved this cycle.
- iss_full  out  1  pending counter of iss_rd is saturated; decode must hold.
- wb_count  out  16  number of committed register writes, wraps.

Behaviour:
- Reset (reset=0, async): all registers 0, all pending counters 0, wb_count 0. Combinational outputs follow from cleared state: rd1=rd2=0, hazard=0, iss_full=0.
- Effective writeback: commit = stg_ena & wb_save & (wb_rd != 0).
- On a commit edge: reg[wb_rd] <= wb_c, wb_count <= wb_count+1 (wraps 0xFFFF->0).
- x0 hardwired to 0: writes ignored, never counted, never pending.
- Read ports:
  - rdN = 0 if rsN==0.
  - Otherwise, if commit and wb_rd==rsN, rdN = wb_c (write-through bypass, same cycle).
  - Otherwise rdN = reg[rsN].
- Scoreboard: per-register pending counter pend[r], PEND_W bits.
  - inc = stg_ena & iss_valid & iss_wr & (iss_rd!=0) & ~iss_full.
  - dec = commit (applies to pend[wb_rd]).
  - Same register, inc and dec in one cycle: counter unchanged.
  - Different registers: both updates apply.
  - dec when pend[wb_rd]==0 (write without prior issue): counter stays 0, no underflow; the write still commits.
  - inc when pend==max: blocked by iss_full, counter holds.
- iss_full = iss_valid & iss_wr & (iss_rd!=0) & (pend[iss_rd]==max). Combinational.
- hazard: for each N, hazardN = (rsN!=0) & (pend[rsN] > (commit & wb_rd==rsN ? 1 : 0)); hazard = hazard1 | hazard2.
  - The sole outstanding write being committed this cycle resolves via the bypass and raises no hazard.
- stg_ena=0: registers, counters and wb_count hold; reads still valid; hazard/iss_full still evaluated.
- Latency: write visible on rd ports in the commit cycle via bypass, and from the next cycle via the array.
- Scoreboard updates take effect on the next cycle.
- Reset asserted mid-operation: all pending state lost, counters 0. Upstream latches reset in the same event, so no stale commits remain.

Test Plan:
- Reset then read: reset low for 2 cycles, release; rs1=5, rs2=0 -> rd1=0, rd2=0, hazard=0, wb_count=0.
- Write and bypass: wb_rd=3, wb_c=0xDEADBEEF, wb_save=1, stg_ena=1, rs1=3 -> rd1=0xDEADBEEF in the same cycle; next cycle with wb_save=0, rd1 still 0xDEADBEEF; wb_count=1.
- x0 protection: wb_rd=0, wb_c=0x1234, wb_save=1 -> rd1(rs1=0)=0, wb_count unchanged.
- RAW hazard: issue iss_rd=7 twice on consecutive cycles; rs1=7 -> hazard=1.
  - First commit to 7: hazard still 1 (pend 2->1).
  - Second commit: hazard=0 in that cycle, rd1=wb_c.
  - Next cycle: pend[7]=0.
- Saturation and simultaneous events: issue to r9 three times -> pend=3; fourth issue -> iss_full=1, pend stays 3. Same cycle as a commit to r9 with a non-full issue -> pend unchanged.
- stg_ena low plus async reset: stg_ena=0 with wb_save=1 -> no write, counters hold. Assert reset mid-cycle -> all pend 0, rd1=0 immediately.

Source files
------------

// File: rtl/reg_file_wb.sv
// Writeback stage: commits ALU results into the register bank, serves two bypassed
// read ports, and keeps a per-register pending-write scoreboard for RAW stalls.

module reg_file_wb_pend #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [PEND_W-1:0] cnt_o
);
    logic [PEND_W-1:0] cnt_q, cnt_d;

    // inc is already blocked upstream at saturation; dec floors at zero so an
    // unannounced write cannot underflow the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i)
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module reg_file_wb #(
    parameter int NREGS  = 32,
    parameter int XLEN   = 32,
    parameter int PEND_W = 2
) (
    input  logic            stg_clk,
    input  logic            reset,
    input  logic            stg_ena,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_c,
    input  logic            wb_save,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic            iss_wr,
    output logic            hazard,
    output logic            iss_full,
    output logic [15:0]     wb_count
);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic                           commit;
    logic                           inc_any;
    logic [NREGS-1:0][PEND_W-1:0]   pend;
    logic [XLEN-1:0]                regs_q [NREGS];
    logic [15:0]                    wb_count_q, wb_count_d;

    assign commit   = stg_ena & wb_save & (wb_rd != 5'd0);
    assign iss_full = iss_valid & iss_wr & (iss_rd != 5'd0) & (pend[iss_rd] == PEND_MAX);
    assign inc_any  = stg_ena & iss_valid & iss_wr & (iss_rd != 5'd0) & ~iss_full;

    // x0 never has a pending write.
    assign pend[0] = '0;

    genvar r;
    generate
        for (r = 1; r < NREGS; r++) begin : g_pend
            reg_file_wb_pend #(.PEND_W(PEND_W)) u_pend (
                .clk   (stg_clk),
                .rst_n (reset),
                .inc_i (inc_any & (iss_rd == 5'(r))),
                .dec_i (commit  & (wb_rd  == 5'(r))),
                .cnt_o (pend[r])
            );
        end
    endgenerate

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[wb_rd] <= wb_c;
        end
    end

    assign wb_count_d = commit ? wb_count_q + 16'd1 : wb_count_q;

    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) wb_count_q <= '0;
        else        wb_count_q <= wb_count_d;
    end

    assign wb_count = wb_count_q;

    // Two identical read ports; a write landing this cycle is forwarded and
    // resolves one outstanding pending write on that register.
    logic [4:0]      rs_v  [2];
    logic [XLEN-1:0] rd_v  [2];
    logic            haz_v [2];

    assign rs_v[0] = rs1;
    assign rs_v[1] = rs2;

    genvar p;
    generate
        for (p = 0; p < 2; p++) begin : g_rd
            logic hit;
            assign hit = commit & (wb_rd == rs_v[p]);

            always_comb begin
                rd_v[p] = regs_q[rs_v[p]];
                if (rs_v[p] == 5'd0) rd_v[p] = '0;
                else if (hit)        rd_v[p] = wb_c;
            end

            assign haz_v[p] = (rs_v[p] != 5'd0) & (pend[rs_v[p]] > PEND_W'(hit));
        end
    endgenerate

    assign rd1    = rd_v[0];
    assign rd2    = rd_v[1];
    assign hazard = haz_v[0] | haz_v[1];
endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized and directed bench for reg_file_wb against an array/counter reference model.

module tb_reg_file_wb;
    logic        stg_clk = 1'b0;
    logic        reset, stg_ena, wb_save, iss_valid, iss_wr;
    logic [4:0]  wb_rd, rs1, rs2, iss_rd;
    logic [31:0] wb_c, rd1, rd2;
    logic        hazard, iss_full;
    logic [15:0] wb_count;

    always #5 stg_clk = ~stg_clk;

    reg_file_wb dut (
        .stg_clk(stg_clk), .reset(reset), .stg_ena(stg_ena),
        .wb_rd(wb_rd), .wb_c(wb_c), .wb_save(wb_save),
        .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_wr(iss_wr),
        .hazard(hazard), .iss_full(iss_full), .wb_count(wb_count)
    );

    // Reference model: architectural state as plain arrays and integers.
    logic [31:0] m_reg  [32];
    int          m_pend [32];
    int          m_cnt;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 0; end
        m_cnt = 0;
    endtask

    function automatic bit m_commit();
        return stg_ena && wb_save && wb_rd != 0;
    endfunction

    function automatic bit m_full();
        return iss_valid && iss_wr && iss_rd != 0 && m_pend[iss_rd] == 3;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] rs);
        if (rs == 0) return '0;
        if (m_commit() && wb_rd == rs) return wb_c;
        return m_reg[rs];
    endfunction

    function automatic bit m_haz(input logic [4:0] rs);
        int thr;
        thr = (m_commit() && wb_rd == rs) ? 1 : 0;
        return rs != 0 && m_pend[rs] > thr;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, ".rd1"},   rd1, m_rd(rs1));
        chk({tag, ".rd2"},   rd2, m_rd(rs2));
        chk({tag, ".haz"},   32'(hazard),   32'(m_haz(rs1) || m_haz(rs2)));
        chk({tag, ".full"},  32'(iss_full), 32'(m_full()));
        chk({tag, ".count"}, 32'(wb_count), 32'(m_cnt));
    endtask

    // Apply one clock of state change from the current inputs.
    task automatic m_update();
        bit com, inc;
        com = m_commit();
        inc = stg_ena && iss_valid && iss_wr && iss_rd != 0 && !m_full();
        if (inc) m_pend[iss_rd]++;
        if (com) begin
            m_reg[wb_rd] = wb_c;
            m_cnt = (m_cnt + 1) % 65536;
            m_pend[wb_rd] = (m_pend[wb_rd] > 0) ? m_pend[wb_rd] - 1 : 0;
        end
    endtask

    task automatic step(input string tag, input bit ena, input logic [4:0] rd, input logic [31:0] c,
                        input bit save, input logic [4:0] r1, input logic [4:0] r2,
                        input bit iv, input logic [4:0] ird, input bit iw);
        @(negedge stg_clk);
        stg_ena = ena; wb_rd = rd; wb_c = c; wb_save = save;
        rs1 = r1; rs2 = r2; iss_valid = iv; iss_rd = ird; iss_wr = iw;
        #1 check_outs(tag);
        @(posedge stg_clk);
        m_update();
    endtask

    task automatic do_reset();
        @(negedge stg_clk);
        reset = 1'b0;
        m_clear();
        repeat (2) @(negedge stg_clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; stg_ena = 0; wb_save = 0; iss_valid = 0; iss_wr = 0;
        wb_rd = 0; wb_c = 0; rs1 = 0; rs2 = 0; iss_rd = 0;
        m_clear();
        do_reset();

        step("rst", 1, 0, 0, 0, 5, 0, 0, 0, 0);
        chk("rst.rd1_lit", rd1, 32'h0);

        step("wr3", 1, 3, 32'hDEADBEEF, 1, 3, 0, 0, 0, 0);
        step("rd3", 1, 3, 32'h0, 0, 3, 3, 0, 0, 0);
        #1 chk("rd3.lit", rd1, 32'hDEADBEEF);
        chk("wr3.cnt_lit", 32'(wb_count), 32'd1);

        step("x0", 1, 0, 32'h1234, 1, 0, 3, 0, 0, 0);
        #1 chk("x0.cnt_lit", 32'(wb_count), 32'd1);

        step("iss7a", 1, 0, 0, 0, 7, 0, 1, 7, 1);
        step("iss7b", 1, 0, 0, 0, 7, 0, 1, 7, 1);
        step("c7a",   1, 7, 32'hA5A5_0001, 1, 7, 0, 0, 0, 0);
        step("c7b",   1, 7, 32'hA5A5_0002, 1, 7, 0, 0, 0, 0);
        step("idle7", 1, 0, 0, 0, 7, 0, 0, 0, 0);
        #1 chk("idle7.haz_lit", 32'(hazard), 32'd0);

        for (int i = 0; i < 4; i++) step("iss9", 1, 0, 0, 0, 0, 9, 1, 9, 1);
        step("full9", 1, 0, 0, 0, 0, 9, 1, 9, 1);
        step("c9",    1, 9, 32'h9, 1, 0, 9, 0, 0, 0);
        step("c9i9",  1, 9, 32'h99, 1, 0, 9, 1, 9, 1);
        step("c9b",   1, 9, 32'h999, 1, 0, 9, 0, 0, 0);
        step("c9c",   1, 9, 32'h9999, 1, 0, 9, 0, 0, 0);
        step("idle9", 1, 0, 0, 0, 0, 9, 0, 0, 0);

        step("ena0",  0, 4, 32'hFFFF_0004, 1, 4, 0, 1, 4, 1);
        step("ena0r", 1, 0, 0, 0, 4, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset mid-cycle with outstanding state.
        step("pre", 1, 5, 32'h5555_AAAA, 1, 0, 0, 1, 6, 1);
        @(negedge stg_clk);
        stg_ena = 1; wb_save = 0; rs1 = 5; rs2 = 6; iss_valid = 0;
        #2 check_outs("premid");
        reset = 1'b0;
        m_clear();
        #1 check_outs("midrst");
        chk("midrst.rd1_lit", rd1, 32'h0);
        @(negedge stg_clk);
        reset = 1'b1;
        step("postrst", 1, 0, 0, 0, 5, 6, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
